// File: rtl/clk_period_meter_if.sv
`timescale 1ns/1ps
// Bundle of the sensed clock input and the measurement results of clk_period_meter.
// The meter is the slave side; whoever drives clk_sense and reads results is the master.
interface clk_period_meter_if #(
   parameter int WIDTH = 16
);
   logic             clk_sense;
   logic [WIDTH-1:0] period;
   logic [WIDTH-1:0] high_time;
   logic             meas_valid;
   logic             locked;
   logic             stalled;

   modport master (
      output clk_sense,
      input  period, high_time, meas_valid, locked, stalled
   );

   modport slave (
      input  clk_sense,
      output period, high_time, meas_valid, locked, stalled
   );
endinterface

// File: rtl/clk_period_meter.sv
`timescale 1ns/1ps
// Measures rise-to-rise period and rise-to-fall high time of a slow signal in clock_in
// cycles, flags a sustained in-tolerance period (locked) and a missing signal (stalled).
module clk_period_meter #(
   parameter int WIDTH    = 16,
   parameter int EXP_DIV  = 10,
   parameter int TOL      = 1,
   parameter int LOCK_CNT = 4
) (
   input  logic              clock_in,
   input  logic              reset,
   clk_period_meter_if.slave mon
);
   localparam int               MW        = $clog2(LOCK_CNT + 1);
   localparam logic [WIDTH:0]   LO_BOUND  = (EXP_DIV > TOL) ? (WIDTH+1)'(EXP_DIV - TOL) : '0;
   localparam logic [WIDTH:0]   HI_BOUND  = (WIDTH+1)'(EXP_DIV + TOL);
   localparam logic [WIDTH-1:0] CNT_MAX   = '1;
   localparam logic [MW-1:0]    LOCK_FULL = MW'(LOCK_CNT);

   typedef enum logic {WAIT_EDGE, MEASURE} state_t;

   state_t           state_q, state_d;
   logic             sync1_q, sync1_d;
   logic             s_sync_q, s_sync_d;
   logic             s_prev_q, s_prev_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] h_cap_q, h_cap_d;
   logic [MW-1:0]    mcount_q, mcount_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic [WIDTH-1:0] high_time_q, high_time_d;
   logic             meas_valid_q, meas_valid_d;
   logic             locked_q, locked_d;
   logic             stalled_q, stalled_d;

   logic             rise;
   logic             fall;
   logic             match;
   logic [MW-1:0]    mcount_inc;

   assign rise       = s_sync_q & ~s_prev_q;
   assign fall       = ~s_sync_q & s_prev_q;
   // Widened by one bit so EXP_DIV+TOL cannot wrap at the top of the counter range.
   assign match      = ({1'b0, cnt_q} >= LO_BOUND) && ({1'b0, cnt_q} <= HI_BOUND);
   assign mcount_inc = (mcount_q == LOCK_FULL) ? LOCK_FULL : mcount_q + 1'b1;

   always_comb begin
      sync1_d      = mon.clk_sense;
      s_sync_d     = sync1_q;
      s_prev_d     = s_sync_q;
      state_d      = state_q;
      cnt_d        = cnt_q;
      h_cap_d      = h_cap_q;
      mcount_d     = mcount_q;
      period_d     = period_q;
      high_time_d  = high_time_q;
      meas_valid_d = 1'b0;
      locked_d     = locked_q;
      stalled_d    = stalled_q;

      case (state_q)
         WAIT_EDGE: begin
            if (rise) begin
               cnt_d     = {{(WIDTH-1){1'b0}}, 1'b1};
               stalled_d = 1'b0;
               state_d   = MEASURE;
            end
         end
         MEASURE: begin
            // A rise always closes the measurement, even when the counter is saturated.
            if (rise) begin
               period_d     = cnt_q;
               high_time_d  = h_cap_q;
               meas_valid_d = 1'b1;
               cnt_d        = {{(WIDTH-1){1'b0}}, 1'b1};
               if (match) begin
                  mcount_d = mcount_inc;
                  locked_d = (mcount_inc == LOCK_FULL);
               end else begin
                  mcount_d = '0;
                  locked_d = 1'b0;
               end
            end else if (cnt_q == CNT_MAX) begin
               stalled_d = 1'b1;
               locked_d  = 1'b0;
               mcount_d  = '0;
               state_d   = WAIT_EDGE;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (fall) begin
                  h_cap_d = cnt_q;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         state_q      <= WAIT_EDGE;
         sync1_q      <= 1'b0;
         s_sync_q     <= 1'b0;
         s_prev_q     <= 1'b0;
         cnt_q        <= '0;
         h_cap_q      <= '0;
         mcount_q     <= '0;
         period_q     <= '0;
         high_time_q  <= '0;
         meas_valid_q <= 1'b0;
         locked_q     <= 1'b0;
         stalled_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync1_q      <= sync1_d;
         s_sync_q     <= s_sync_d;
         s_prev_q     <= s_prev_d;
         cnt_q        <= cnt_d;
         h_cap_q      <= h_cap_d;
         mcount_q     <= mcount_d;
         period_q     <= period_d;
         high_time_q  <= high_time_d;
         meas_valid_q <= meas_valid_d;
         locked_q     <= locked_d;
         stalled_q    <= stalled_d;
      end
   end

   assign mon.period     = period_q;
   assign mon.high_time  = high_time_q;
   assign mon.meas_valid = meas_valid_q;
   assign mon.locked     = locked_q;
   assign mon.stalled    = stalled_q;

endmodule

// File: tb/tb_clk_period_meter.sv
`timescale 1ns/1ps
// Directed bench for clk_period_meter: a table of high/low patterns with hand-computed
// results, followed by hand-written stall, async-reset and asynchronous-input sequences.
module tb_clk_period_meter;
   localparam int WIDTH = 16;

   logic clock_in = 1'b0;
   logic reset    = 1'b1;

   clk_period_meter_if #(.WIDTH(WIDTH)) mif ();

   clk_period_meter #(
      .WIDTH    (WIDTH),
      .EXP_DIV  (10),
      .TOL      (1),
      .LOCK_CNT (4)
   ) dut (
      .clock_in (clock_in),
      .reset    (reset),
      .mon      (mif)
   );

   always #5 clock_in = ~clock_in;

   typedef struct {
      int hi;
      int lo;
      int n;
      int exp_count;
      int exp_period;
      int exp_high;
      int exp_locked;
      int exp_lock_pen;
   } vec_t;

   typedef struct {
      int period;
      int high;
      int locked;
      int cyc;
   } rec_t;

   rec_t rec_q[$];
   int   cyc           = 0;
   int   wide_cnt      = 0;
   logic mv_prev       = 1'b0;
   int   errors        = 0;
   int   checks        = 0;
   int   last_rise_cyc = 0;

   always @(posedge clock_in) cyc <= cyc + 1;

   // Every meas_valid sample is logged; back-to-back samples mean a pulse wider than one cycle.
   always @(negedge clock_in) begin
      if (mif.meas_valid)
         rec_q.push_back('{int'(mif.period), int'(mif.high_time), int'(mif.locked), cyc});
      if (mif.meas_valid && mv_prev)
         wide_cnt++;
      mv_prev = mif.meas_valid;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drives n periods of hi cycles high then lo cycles low, starting with a rise.
   task automatic applyStimulus(input int hi, input int lo, input int n);
      for (int i = 0; i < n; i++) begin
         mif.clk_sense = 1'b1;
         last_rise_cyc = cyc;
         repeat (hi) begin @(posedge clock_in); #1; end
         mif.clk_sense = 1'b0;
         repeat (lo) begin @(posedge clock_in); #1; end
      end
   endtask

   initial begin
      vec_t vecs[6];
      rec_t none;
      rec_t last;
      rec_t pen;
      int   base;
      int   got_n;
      int   stall_seen;
      int   stall_cyc;
      int   bad;
      int   unlocked;

      none = '{-1, -1, -1, -1};
      vecs[0] = '{5, 5, 5, 4, 10, 5, 1, 0};
      vecs[1] = '{6, 5, 2, 2, 11, 6, 1, 1};
      vecs[2] = '{6, 6, 4, 4, 12, 6, 0, 0};
      vecs[3] = '{5, 5, 5, 5, 10, 5, 1, 0};
      vecs[4] = '{3, 9, 4, 4, 12, 3, 0, 0};
      vecs[5] = '{5, 5, 5, 5, 10, 5, 1, 0};

      mif.clk_sense = 1'b0;
      repeat (2) @(posedge clock_in);
      #1 reset = 1'b0;
      @(posedge clock_in); #1;
      checkOutput("reset_period",     int'(mif.period),     0);
      checkOutput("reset_high_time",  int'(mif.high_time),  0);
      checkOutput("reset_meas_valid", int'(mif.meas_valid), 0);
      checkOutput("reset_locked",     int'(mif.locked),     0);
      checkOutput("reset_stalled",    int'(mif.stalled),    0);

      for (int r = 0; r < 6; r++) begin
         base = rec_q.size();
         applyStimulus(vecs[r].hi, vecs[r].lo, vecs[r].n);
         got_n = rec_q.size() - base;
         last  = (got_n > 0) ? rec_q[rec_q.size()-1] : none;
         pen   = (got_n > 1) ? rec_q[rec_q.size()-2] : none;
         checkOutput($sformatf("row%0d_count", r),      got_n,       vecs[r].exp_count);
         checkOutput($sformatf("row%0d_period", r),     last.period, vecs[r].exp_period);
         checkOutput($sformatf("row%0d_high_time", r),  last.high,   vecs[r].exp_high);
         checkOutput($sformatf("row%0d_locked", r),     last.locked, vecs[r].exp_locked);
         checkOutput($sformatf("row%0d_locked_pen", r), pen.locked,  vecs[r].exp_lock_pen);
         if (r == 2 && got_n > 1) begin
            checkOutput("first_12_period", rec_q[base+1].period, 12);
            checkOutput("first_12_unlock", rec_q[base+1].locked, 0);
         end
         if (r == 4 && got_n == 4) begin
            for (int k = 1; k < 4; k++)
               checkOutput($sformatf("duty_gap%0d", k), rec_q[base+k].cyc - rec_q[base+k-1].cyc, 12);
         end
      end

      // Stall: clk_sense held low after the lock from the last table row.
      base       = rec_q.size();
      stall_seen = 0;
      stall_cyc  = 0;
      for (int i = 0; i < 70000; i++) begin
         @(negedge clock_in);
         if (mif.stalled) begin
            stall_seen = 1;
            stall_cyc  = cyc;
            break;
         end
      end
      checkOutput("stall_seen",      stall_seen,                  1);
      checkOutput("stall_delay",     stall_cyc - last_rise_cyc,   65538);
      checkOutput("stall_locked",    int'(mif.locked),            0);
      checkOutput("stall_period",    int'(mif.period),            10);
      checkOutput("stall_high_time", int'(mif.high_time),         5);
      checkOutput("stall_no_meas",   rec_q.size() - base,         0);
      @(posedge clock_in); #1;

      base = rec_q.size();
      applyStimulus(5, 5, 1);
      checkOutput("unstall_cleared", int'(mif.stalled),   0);
      checkOutput("unstall_no_meas", rec_q.size() - base, 0);
      applyStimulus(5, 5, 1);
      got_n = rec_q.size() - base;
      last  = (got_n > 0) ? rec_q[rec_q.size()-1] : none;
      checkOutput("restart_count",   got_n,                        1);
      checkOutput("restart_period",  last.period,                  10);
      checkOutput("restart_high",    last.high,                    5);
      checkOutput("restart_latency", last.cyc - last_rise_cyc,     3);
      checkOutput("restart_locked",  last.locked,                  0);

      // Async reset pulse in the low phase, between clock edges.
      mif.clk_sense = 1'b1;
      repeat (5) begin @(posedge clock_in); #1; end
      mif.clk_sense = 1'b0;
      repeat (2) begin @(posedge clock_in); #1; end
      #2 reset = 1'b1;
      #0.5;
      checkOutput("areset_period",     int'(mif.period),     0);
      checkOutput("areset_high_time",  int'(mif.high_time),  0);
      checkOutput("areset_meas_valid", int'(mif.meas_valid), 0);
      checkOutput("areset_locked",     int'(mif.locked),     0);
      checkOutput("areset_stalled",    int'(mif.stalled),    0);
      #0.5 reset = 1'b0;
      repeat (3) begin @(posedge clock_in); #1; end
      base = rec_q.size();
      applyStimulus(5, 5, 2);
      got_n = rec_q.size() - base;
      last  = (got_n > 0) ? rec_q[rec_q.size()-1] : none;
      checkOutput("post_reset_count",  got_n,       1);
      checkOutput("post_reset_period", last.period, 10);
      checkOutput("post_reset_high",   last.high,   5);

      // Asynchronous input: 10.3-cycle period with an arbitrary phase.
      base = rec_q.size();
      #3.7;
      for (int i = 0; i < 20; i++) begin
         mif.clk_sense = 1'b1;
         #51.5;
         mif.clk_sense = 1'b0;
         #51.5;
      end
      @(posedge clock_in); #1;
      got_n    = rec_q.size() - base;
      bad      = 0;
      unlocked = 0;
      for (int k = 0; k < got_n; k++) begin
         if (rec_q[base+k].period < 10 || rec_q[base+k].period > 11) bad++;
         if (k >= 3 && rec_q[base+k].locked != 1) unlocked++;
      end
      last = (got_n > 0) ? rec_q[rec_q.size()-1] : none;
      checkOutput("async_count",        got_n,       20);
      checkOutput("async_out_of_range", bad,         0);
      checkOutput("async_unlocked",     unlocked,    0);
      checkOutput("async_final_locked", last.locked, 1);

      checkOutput("meas_valid_width", wide_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Measures the period and high time of a slow clock-like signal, such as the output of a clock divider, in cycles of the system clock. It flags when the measured period stays within tolerance of an expected value, and when the signal stops toggling. It sits on the consuming side of divided clocks, providing bring-up, lock and health monitoring of generated clock outputs.

## Interface
- WIDTH, 16, width of all cycle counters and measurement outputs.
- EXP_DIV, 10, expected period of clk_sense in clock_in cycles.
- TOL, 1, allowed absolute deviation from EXP_DIV, in cycles.
- LOCK_CNT, 4, consecutive in-tolerance measurements required to assert locked.

Ports:
- clock_in  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- clk_sense  input  1  measured signal, asynchronous to clock_in.
- period  output  WIDTH  last measured rise-to-rise interval, in clock_in cycles.
- high_time  output  WIDTH  last measured rise-to-fall interval, in clock_in cycles.
- meas_valid  output  1  single-cycle pulse when period and high_time update.
- locked  output  1  period has been in tolerance for LOCK_CNT consecutive measurements.
- stalled  output  1  counter saturated with no rising edge seen.

## Operation
- **Synchronizer:** 2-flop synchronizer on clk_sense produces s_sync. A third flop produces s_prev.
  - rise = s_sync & ~s_prev.
  - fall = ~s_sync & s_prev.
- **FSM states:** WAIT_EDGE (reset state) and MEASURE.
- **WAIT_EDGE:**
  - On rise: cnt <= 1, stalled <= 0, go to MEASURE.
  - No measurement is produced.
- **MEASURE, no rise this cycle:**
  - cnt <= cnt + 1.
  - On fall: h_cap <= cnt.
- **MEASURE, rise this cycle:**
  - period <= cnt, high_time <= h_cap, meas_valid <= 1.
  - cnt <= 1.
  - Stay in MEASURE.
- **Saturation:** if cnt == 2^WIDTH-1 in MEASURE with no rise, apply all of the following in the same cycle:
  - stalled <= 1, locked <= 0, mcount <= 0.
  - Go to WAIT_EDGE.
  - period and high_time hold their last values.
- **Match rule:** match = (period_new >= EXP_DIV-TOL) && (period_new <= EXP_DIV+TOL).
  - Evaluate with WIDTH+1-bit unsigned arithmetic.
  - Lower bound clamps at 0.
- **Lock counter:** evaluated on each measurement.
  - On match: mcount increments, saturating at LOCK_CNT. locked <= 1 when the new mcount == LOCK_CNT.
  - On mismatch: mcount <= 0 and locked <= 0, on the same edge as meas_valid.
- meas_valid is low in every cycle without a new measurement.
- **Reset value of every output:** 0 (period, high_time, meas_valid, locked, stalled).
- **Reset of internal state:** synchronizer flops, s_prev, cnt, h_cap and mcount all reset to 0; FSM resets to WAIT_EDGE.
- Reset mid-measurement discards the partial count. The first rise after reset release is a reference edge only and produces no meas_valid.

## Timing
- **Latency:** clk_sense rising edge sampled at clock edge k; s_sync goes high at edge k+1; outputs update at edge k+2.
  - meas_valid is high for the one cycle following edge k+2.
  - Period, high_time and locked are stable from that edge until the next measurement.
- **Minimum measurable input:** clk_sense high ≥ 2 cycles and low ≥ 2 cycles, giving a period ≥ 4. Shorter pulses may be missed by the synchronizer; behaviour is not required to be correct.
- Measurement resolution is ±1 cycle for asynchronous input due to synchronizer sampling. Measurement is exact for input generated from clock_in.
- Rise and saturation in the same cycle: rise wins (normal measurement, no stall).
- stalled asserts exactly 2^WIDTH-1 cycles after the last rise. It stays set until the next rise in WAIT_EDGE.

## Test plan
- **Locking:** clk_sense from clock_in, 5 high / 5 low, defaults -> first meas_valid on the second rise with period=10, high_time=5. locked=0 after 3 measurements; locked=1 on the 4th meas_valid.
- **Tolerance:** after lock, switch to 6 high / 5 low -> period=11, locked stays 1. Then 6 high / 6 low -> period=12, locked=0 on that meas_valid edge; 4 further in-tolerance periods are required to relock.
- **Duty cycle:** 3 high / 9 low -> period=12, high_time=3 on every meas_valid. Each meas_valid pulse is exactly 1 cycle wide and pulses are 12 cycles apart.
- **Stall:** after lock, hold clk_sense low -> stalled=1 and locked=0 65535 cycles after the last rise. The next rise clears stalled with no meas_valid; the following rise gives meas_valid with the correct period.
- **Async reset:** assert reset mid-period for 1 ns, off clock edge -> all outputs 0 immediately. The first rise after release gives no meas_valid; the second gives period=10.
- **Asynchronous input:** clk_sense with a 10.3-cycle period, unrelated phase -> every measured period is 10 or 11. locked holds 1 under default TOL=1.
